tsc_multicycle_cpu: RTL and testbench
=====================================

Name: tsc_multicycle_cpu

Overview:
- Multi-cycle successor of the single-cycle TSC core.
- Executes the 16-bit TSC ISA, with opcode and func encodings taken from opcodes.v.
- Uses an explicit state machine clocked by clk against the same single-port memory handshake (readM/writeM/address/data/inputReady/ackOutput).
- Parametrised reset vector, link register and memory timeout. Adds WWD output, HLT, a retired-instruction counter and an error state.

Parameters:
- WORD_SIZE, 16: datapath/address width. Only 16 is supported because instruction field positions are fixed.
- RESET_PC, 0: pc value loaded on reset.
- LINK_REG, 2: register written by JAL/JRL with the return address.
- MEM_TIMEOUT, 0: maximum cycles to wait for inputReady/ackOutput. 0 means wait forever.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous active-low reset.
- readM  output  1  memory read request.
- writeM  output  1  memory write request.
- address  output  WORD_SIZE  memory address.
- data  inout  WORD_SIZE  driven only while writeM=1, else high-Z.
- inputReady  input  1  read data valid; sampled at posedge.
- ackOutput  input  1  write complete; sampled at posedge.
- output_port  output  WORD_SIZE  value of the last WWD.
- num_inst  output  WORD_SIZE  retired-instruction count.
- is_halted  output  1  set after HLT retires.
- is_error  output  1  set on memory timeout or undefined opcode/func.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - state=IF, pc=RESET_PC, regs r0-r3=0.
  - readM=0, writeM=0, address=0, output_port=0, num_inst=0, is_halted=0, is_error=0.
  - Reset mid-access drops readM/writeM immediately.
- States: IF -> ID -> EX -> [MEM] -> WB -> IF. Terminal states: HALT, ERR.
- IF:
  - readM=1, address=pc.
  - At the first posedge with inputReady=1: latch data into IR, deassert readM, go to ID.
  - Wait-cycle counter: if MEM_TIMEOUT>0 and it reaches MEM_TIMEOUT, go to ERR.
- ID (1 cycle):
  - Decode IR[15:12] opcode, rs=IR[11:10], rt=IR[9:8], rd=IR[7:6], func=IR[5:0], imm=IR[7:0] sign-extended, target=IR[11:0].
  - Latch A=R[rs], B=R[rt].
  - Undefined opcode/func -> ERR.
- EX (1 cycle):
  - R-type ALU ops ADD/SUB/AND/ORR/NOT/TCP/SHL/SHR: result = 16-bit wrap, SHL/SHR by 1 bit, SHR arithmetic.
  - ADI: A+sext(imm). ORI: A | zero-extended imm. LHI: {imm,8'h00}.
  - Effective address for LWD/SWD = A+sext(imm).
  - next_pc defaults to pc+1.
  - Branches with target pc+1+sext(imm), condition on signed values:
    - BNE: A!=B. BEQ: A==B.
    - BGZ: A>0. BLZ: A<0.
  - JMP/JAL: next_pc={pc[15:12],target}.
  - JPR/JRL: next_pc=A.
  - JAL/JRL link value = pc+1.
- MEM (LWD/SWD only):
  - LWD: readM=1, address=EA. Latch data at posedge with inputReady=1.
  - SWD: writeM=1, address=EA, data=B. Release at posedge with ackOutput=1.
  - Same MEM_TIMEOUT rule as IF.
  - readM and writeM are never both 1.
- WB (1 cycle):
  - Register write: rd for R-type ALU ops; rt for ADI/ORI/LHI/LWD; LINK_REG for JAL/JRL.
  - WWD: output_port=A.
  - pc=next_pc, num_inst+=1 (wraps at 2^WORD_SIZE).
  - HLT: go to HALT and set is_halted=1 (HLT counts as retired). Otherwise go to IF.
- Register writes happen only in WB. A write to LINK_REG by JRL when rs==LINK_REG uses the pre-write A for the jump.
- HALT and ERR:
  - Hold all state, readM=writeM=0.
  - Only reset exits.
  - ERR sets is_error=1; num_inst is not incremented for the failing instruction.
- Cycle counts with zero-wait memory (inputReady on the first request cycle):
  - ALU/branch/jump: 4 cycles.
  - LWD/SWD: 5 cycles.

Test Plan:
- Reset: hold reset_n=0 mid-IF with readM=1 -> readM drops asynchronously; after release, first fetch address=RESET_PC=0 and num_inst=0.
- Program LHI r1,0x12; ORI r1,r1,0x34; WWD r1; HLT -> output_port=16'h1234, num_inst=4, is_halted=1, no further readM.
- ADI r0,r0,-1 then BLZ r0,+2 -> r0=16'hFFFF, branch taken, next fetch address=pc_BLZ+3. Repeat with BGZ: not taken, next fetch address=pc+1.
- SWD r2,r0,5 with r0=16'h0010, r2=16'h00AB, ackOutput delayed 3 cycles -> writeM=1, address=16'h0015, data=16'h00AB held for 3 cycles; a following LWD r3,r0,5 yields r3=16'h00AB.
- JAL 0x040 at pc=16'h0007 -> r2=16'h0008, next fetch=16'h0040. JRL r2 at 16'h0040 -> r2=16'h0041, next fetch=16'h0008.
- MEM_TIMEOUT=4 with inputReady held low during IF -> is_error=1 after 4 wait cycles, readM=0, num_inst unchanged.

Source files
------------

// File: rtl/tsc_multicycle_cpu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tsc_multicycle_cpu_if                                     |
// | Purpose  : Single-port memory handshake between the multi-cycle TSC  |
// |            core (master) and its memory (slave).                     |
// | Signals  : readM      - read request from the core                   |
// |            writeM     - write request from the core                  |
// |            address    - word address of the access                   |
// |            inputReady - read data valid, sampled at posedge          |
// |            ackOutput  - write complete, sampled at posedge           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface tsc_multicycle_cpu_if #(
   parameter int WORD_SIZE = 16
);
   logic                 readM;
   logic                 writeM;
   logic [WORD_SIZE-1:0] address;
   logic                 inputReady;
   logic                 ackOutput;

   modport master (
      output readM, writeM, address,
      input  inputReady, ackOutput
   );

   modport slave (
      input  readM, writeM, address,
      output inputReady, ackOutput
   );
endinterface
`default_nettype wire

// File: rtl/tsc_multicycle_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tsc_multicycle_cpu                                        |
// | Purpose  : Multi-cycle TSC core. IF -> ID -> EX -> [MEM] -> WB with  |
// |            terminal HALT and ERR states, WWD output port, retired    |
// |            instruction counter and bounded memory wait.              |
// | Ports    : clk         - system clock, posedge                       |
// |            reset_n     - asynchronous active-low reset               |
// |            mem         - memory handshake (readM/writeM/address/     |
// |                          inputReady/ackOutput), master side          |
// |            data        - bidirectional data bus, driven only while   |
// |                          writeM=1                                    |
// |            output_port - operand of the last WWD                     |
// |            num_inst    - retired instruction count                   |
// |            is_halted   - HLT has retired                             |
// |            is_error    - memory timeout or undefined instruction     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tsc_multicycle_cpu #(
   parameter int                   WORD_SIZE   = 16,
   parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
   parameter int                   LINK_REG    = 2,
   parameter int                   MEM_TIMEOUT = 0
) (
   input  wire                         clk,
   input  wire                         reset_n,
   tsc_multicycle_cpu_if.master        mem,
   inout  wire  [WORD_SIZE-1:0]        data,
   output logic [WORD_SIZE-1:0]        output_port,
   output logic [WORD_SIZE-1:0]        num_inst,
   output logic                        is_halted,
   output logic                        is_error
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   localparam logic [3:0] c_OP_BNE = 4'd0;
   localparam logic [3:0] c_OP_BEQ = 4'd1;
   localparam logic [3:0] c_OP_BGZ = 4'd2;
   localparam logic [3:0] c_OP_BLZ = 4'd3;
   localparam logic [3:0] c_OP_ADI = 4'd4;
   localparam logic [3:0] c_OP_ORI = 4'd5;
   localparam logic [3:0] c_OP_LHI = 4'd6;
   localparam logic [3:0] c_OP_LWD = 4'd7;
   localparam logic [3:0] c_OP_SWD = 4'd8;
   localparam logic [3:0] c_OP_JMP = 4'd9;
   localparam logic [3:0] c_OP_JAL = 4'd10;
   localparam logic [3:0] c_OP_ALU = 4'd15;

   localparam logic [5:0] c_FN_ADD = 6'd0;
   localparam logic [5:0] c_FN_SUB = 6'd1;
   localparam logic [5:0] c_FN_AND = 6'd2;
   localparam logic [5:0] c_FN_ORR = 6'd3;
   localparam logic [5:0] c_FN_NOT = 6'd4;
   localparam logic [5:0] c_FN_TCP = 6'd5;
   localparam logic [5:0] c_FN_SHL = 6'd6;
   localparam logic [5:0] c_FN_SHR = 6'd7;
   localparam logic [5:0] c_FN_JPR = 6'd25;
   localparam logic [5:0] c_FN_JRL = 6'd26;
   localparam logic [5:0] c_FN_WWD = 6'd28;
   localparam logic [5:0] c_FN_HLT = 6'd29;

   localparam logic [1:0]  c_LINK       = 2'(LINK_REG);
   localparam bit          c_TIMEOUT_EN = (MEM_TIMEOUT > 0);
   localparam logic [31:0] c_TIMEOUT    = 32'(MEM_TIMEOUT);

   state_t                 state_q, state_d;
   logic [WORD_SIZE-1:0]   pc_q, pc_d;
   logic [WORD_SIZE-1:0]   ir_q, ir_d;
   logic [WORD_SIZE-1:0]   a_q, a_d;
   logic [WORD_SIZE-1:0]   b_q, b_d;
   // res holds ALU result, effective address, then load data, or link value
   logic [WORD_SIZE-1:0]   res_q, res_d;
   logic [WORD_SIZE-1:0]   npc_q, npc_d;
   logic [WORD_SIZE-1:0]   out_q, out_d;
   logic [WORD_SIZE-1:0]   ninst_q, ninst_d;
   logic [31:0]            wait_q, wait_d;
   logic [WORD_SIZE-1:0]   regs_q [4];
   logic [WORD_SIZE-1:0]   regs_d [4];

   logic                   w_rd_req;
   logic                   w_wr_req;
   logic [WORD_SIZE-1:0]   w_addr;

   // Instruction fields
   logic [3:0]             w_op;
   logic [1:0]             w_rs, w_rt, w_rd;
   logic [5:0]             w_func;
   logic [7:0]             w_imm;
   logic [11:0]            w_target;
   logic [WORD_SIZE-1:0]   w_sext;
   logic [WORD_SIZE-1:0]   w_pc1;
   logic                   w_is_alu, w_is_mem, w_valid, w_timeout;

   assign w_op     = ir_q[15:12];
   assign w_rs     = ir_q[11:10];
   assign w_rt     = ir_q[9:8];
   assign w_rd     = ir_q[7:6];
   assign w_func   = ir_q[5:0];
   assign w_imm    = ir_q[7:0];
   assign w_target = ir_q[11:0];
   assign w_sext   = {{8{w_imm[7]}}, w_imm};
   assign w_pc1    = pc_q + 16'd1;
   assign w_is_alu = (w_op == c_OP_ALU) && (w_func <= c_FN_SHR);
   assign w_is_mem = (w_op == c_OP_LWD) || (w_op == c_OP_SWD);

   // The wait counter already holds the cycles spent; this edge would be one more.
   assign w_timeout = c_TIMEOUT_EN && ((wait_q + 32'd1) >= c_TIMEOUT);

   always_comb begin
      w_valid = 1'b0;
      case (w_op)
         c_OP_BNE, c_OP_BEQ, c_OP_BGZ, c_OP_BLZ, c_OP_ADI, c_OP_ORI,
         c_OP_LHI, c_OP_LWD, c_OP_SWD, c_OP_JMP, c_OP_JAL: w_valid = 1'b1;
         c_OP_ALU: w_valid = w_is_alu || (w_func == c_FN_JPR) || (w_func == c_FN_JRL) ||
                             (w_func == c_FN_WWD) || (w_func == c_FN_HLT);
         default:  w_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      npc_d    = npc_q;
      out_d    = out_q;
      ninst_d  = ninst_q;
      wait_d   = wait_q;
      regs_d   = regs_q;
      w_rd_req = 1'b0;
      w_wr_req = 1'b0;
      w_addr   = '0;

      case (state_q)
         S_IF: begin
            w_rd_req = 1'b1;
            w_addr   = pc_q;
            if (mem.inputReady) begin
               ir_d    = data;
               wait_d  = '0;
               state_d = S_ID;
            end else if (w_timeout) begin
               wait_d  = '0;
               state_d = S_ERR;
            end else begin
               wait_d  = wait_q + 32'd1;
            end
         end

         S_ID: begin
            a_d     = regs_q[w_rs];
            b_d     = regs_q[w_rt];
            state_d = w_valid ? S_EX : S_ERR;
         end

         S_EX: begin
            npc_d = w_pc1;
            res_d = '0;
            case (w_op)
               c_OP_ALU: begin
                  case (w_func)
                     c_FN_ADD: res_d = a_q + b_q;
                     c_FN_SUB: res_d = a_q - b_q;
                     c_FN_AND: res_d = a_q & b_q;
                     c_FN_ORR: res_d = a_q | b_q;
                     c_FN_NOT: res_d = ~a_q;
                     c_FN_TCP: res_d = ~a_q + 16'd1;
                     c_FN_SHL: res_d = {a_q[14:0], 1'b0};
                     c_FN_SHR: res_d = {a_q[15], a_q[15:1]};
                     c_FN_JPR: npc_d = a_q;
                     c_FN_JRL: begin
                        npc_d = a_q;
                        res_d = w_pc1;
                     end
                     default:  res_d = '0;
                  endcase
               end
               c_OP_ADI: res_d = a_q + w_sext;
               c_OP_ORI: res_d = a_q | {8'h00, w_imm};
               c_OP_LHI: res_d = {w_imm, 8'h00};
               c_OP_LWD, c_OP_SWD: res_d = a_q + w_sext;
               c_OP_BNE: if (a_q != b_q)         npc_d = w_pc1 + w_sext;
               c_OP_BEQ: if (a_q == b_q)         npc_d = w_pc1 + w_sext;
               c_OP_BGZ: if ($signed(a_q) > 0)   npc_d = w_pc1 + w_sext;
               c_OP_BLZ: if (a_q[15])            npc_d = w_pc1 + w_sext;
               c_OP_JMP: npc_d = {pc_q[15:12], w_target};
               c_OP_JAL: begin
                  npc_d = {pc_q[15:12], w_target};
                  res_d = w_pc1;
               end
               default:  res_d = '0;
            endcase
            state_d = w_is_mem ? S_MEM : S_WB;
         end

         S_MEM: begin
            w_addr = res_q;
            if (w_op == c_OP_LWD) begin
               w_rd_req = 1'b1;
            end else begin
               w_wr_req = 1'b1;
            end
            if ((w_op == c_OP_LWD) ? mem.inputReady : mem.ackOutput) begin
               if (w_op == c_OP_LWD) begin
                  res_d = data;
               end
               wait_d  = '0;
               state_d = S_WB;
            end else if (w_timeout) begin
               wait_d  = '0;
               state_d = S_ERR;
            end else begin
               wait_d  = wait_q + 32'd1;
            end
         end

         S_WB: begin
            if (w_is_alu) begin
               regs_d[w_rd] = res_q;
            end else if ((w_op == c_OP_ADI) || (w_op == c_OP_ORI) ||
                         (w_op == c_OP_LHI) || (w_op == c_OP_LWD)) begin
               regs_d[w_rt] = res_q;
            end else if ((w_op == c_OP_JAL) ||
                         ((w_op == c_OP_ALU) && (w_func == c_FN_JRL))) begin
               // Jump target was taken from A in EX, so overwriting rs here is safe.
               regs_d[c_LINK] = res_q;
            end
            if ((w_op == c_OP_ALU) && (w_func == c_FN_WWD)) begin
               out_d = a_q;
            end
            pc_d    = npc_q;
            ninst_d = ninst_q + 16'd1;
            state_d = ((w_op == c_OP_ALU) && (w_func == c_FN_HLT)) ? S_HALT : S_IF;
         end

         default: begin
            // HALT and ERR hold everything until reset.
            state_d = state_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IF;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         npc_q   <= '0;
         out_q   <= '0;
         ninst_q <= '0;
         wait_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         npc_q   <= npc_d;
         out_q   <= out_d;
         ninst_q <= ninst_d;
         wait_q  <= wait_d;
         regs_q  <= regs_d;
      end
   end

   // Requests are gated by reset_n so an access in flight drops the moment
   // reset asserts, and address reads 0 while reset is held.
   assign mem.readM   = reset_n & w_rd_req;
   assign mem.writeM  = reset_n & w_wr_req;
   assign mem.address = reset_n ? w_addr : '0;
   assign data        = mem.writeM ? b_q : {WORD_SIZE{1'bz}};

   assign output_port = out_q;
   assign num_inst    = ninst_q;
   assign is_halted   = (state_q == S_HALT);
   assign is_error    = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_tsc_multicycle_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tsc_multicycle_cpu                                     |
// | Purpose  : Self-checking bench for tsc_multicycle_cpu: small programs |
// |            in a behavioural memory, bus transactions checked against |
// |            an expected-transaction queue, final state checked after  |
// |            HLT or ERR.                                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tsc_multicycle_cpu;
   localparam int W = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   tsc_multicycle_cpu_if #(.WORD_SIZE(W)) mif ();
   wire  [W-1:0] data;
   logic [W-1:0] output_port;
   logic [W-1:0] num_inst;
   logic         is_halted;
   logic         is_error;

   tsc_multicycle_cpu #(
      .WORD_SIZE   (W),
      .RESET_PC    (16'h0000),
      .LINK_REG    (2),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem         (mif),
      .data        (data),
      .output_port (output_port),
      .num_inst    (num_inst),
      .is_halted   (is_halted),
      .is_error    (is_error)
   );

   logic [W-1:0] memory [0:255];
   assign data = mif.readM ? memory[mif.address[7:0]] : {W{1'bz}};

   int    total = 0;
   int    bad   = 0;
   string tname = "none";

   int rd_budget = -1;   // read handshakes still granted, -1 = unlimited
   int wr_delay  = 0;
   int wr_wait   = 0;
   int both_cnt  = 0;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } txn_t;
   txn_t exp_q[$];

   typedef struct {
      logic [5:0]  fn;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
   } alu_vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s/%s: got %h expected %h", tname, name, act, exp);
      end
   endtask

   function automatic logic [15:0] enc_r(input logic [5:0] fn, input logic [1:0] rs,
                                          input logic [1:0] rt, input logic [1:0] rd);
      return {4'hF, rs, rt, rd, fn};
   endfunction

   function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [1:0] rs,
                                          input logic [1:0] rt, input logic [7:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [11:0] tgt);
      return {op, tgt};
   endfunction

   function automatic void push_rd(input logic [15:0] addr);
      txn_t t;
      t.wr = 1'b0; t.addr = addr; t.wdata = '0;
      exp_q.push_back(t);
   endfunction

   function automatic void push_wr(input logic [15:0] addr, input logic [15:0] d);
      txn_t t;
      t.wr = 1'b1; t.addr = addr; t.wdata = d;
      exp_q.push_back(t);
   endfunction

   task automatic sb_check(input bit wr, input logic [15:0] addr, input logic [15:0] d);
      txn_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s/sb_extra: got access wr=%0d addr=%h expected none", tname, wr, addr);
      end else begin
         e = exp_q.pop_front();
         chk("sb_kind", 32'(wr), 32'(e.wr));
         chk("sb_addr", 32'(addr), 32'(e.addr));
         if (e.wr) chk("sb_wdata", 32'(d), 32'(e.wdata));
      end
   endtask

   // Memory responder: acts at negedges, handshakes complete at the next posedge.
   int rcnt = 0;
   initial begin
      mif.inputReady = 1'b0;
      mif.ackOutput  = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n || mif.inputReady || mif.ackOutput) begin
            mif.inputReady = 1'b0;
            mif.ackOutput  = 1'b0;
            rcnt = 0;
         end else begin
            if (mif.readM && mif.writeM) both_cnt++;
            if (mif.readM) begin
               if (rd_budget != 0) begin
                  mif.inputReady = 1'b1;
                  if (rd_budget > 0) rd_budget--;
                  sb_check(1'b0, mif.address, '0);
               end
            end else if (mif.writeM) begin
               if (rcnt >= wr_delay) begin
                  mif.ackOutput = 1'b1;
                  memory[mif.address[7:0]] = data;
                  sb_check(1'b1, mif.address, data);
               end else begin
                  rcnt++;
                  wr_wait++;
                  if (exp_q.size() != 0 && exp_q[0].wr) begin
                     chk("wr_hold_addr", 32'(mif.address), 32'(exp_q[0].addr));
                     chk("wr_hold_data", 32'(data), 32'(exp_q[0].wdata));
                  end
               end
            end
         end
      end
   end

   task automatic clear_prog(input string name);
      reset_n = 1'b0;
      tname   = name;
      @(negedge clk);
      for (int i = 0; i < 256; i++) memory[i] = 16'hB000;
      exp_q.delete();
      rd_budget = -1;
      wr_delay  = 0;
      wr_wait   = 0;
      both_cnt  = 0;
   endtask

   // Release mid high phase so the first IF cycle is a full request cycle.
   task automatic start();
      @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (is_halted || is_error) break;
      end
      chk("done", 32'(is_halted | is_error), 32'd1);
   endtask

   task automatic finish_prog(input logic [15:0] exp_out, input logic [15:0] exp_num,
                              input bit exp_halt, input int exp_cyc, input int cyc);
      int idle_rd;
      chk("output_port", 32'(output_port), 32'(exp_out));
      chk("num_inst", 32'(num_inst), 32'(exp_num));
      chk("is_halted", 32'(is_halted), 32'(exp_halt));
      chk("is_error", 32'(is_error), 32'(!exp_halt));
      chk("sb_missing", 32'(exp_q.size()), 32'd0);
      chk("rd_wr_overlap", 32'(both_cnt), 32'd0);
      if (exp_cyc > 0) chk("cycles", 32'(cyc), 32'(exp_cyc));
      idle_rd = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mif.readM || mif.writeM) idle_rd++;
      end
      chk("idle_bus", 32'(idle_rd), 32'd0);
      chk("num_inst_hold", 32'(num_inst), 32'(exp_num));
   endtask

   alu_vec_t vecs [11];
   logic [15:0] bad_words [2];

   initial begin
      int cyc;

      vecs[0]  = '{6'd0, 16'h7FFF, 16'h0001, 16'h8000};
      vecs[1]  = '{6'd0, 16'hFFFF, 16'h0002, 16'h0001};
      vecs[2]  = '{6'd1, 16'h0005, 16'h0007, 16'hFFFE};
      vecs[3]  = '{6'd2, 16'hF0F0, 16'h3C3C, 16'h3030};
      vecs[4]  = '{6'd3, 16'hF000, 16'h000F, 16'hF00F};
      vecs[5]  = '{6'd4, 16'h1234, 16'h0000, 16'hEDCB};
      vecs[6]  = '{6'd5, 16'h0001, 16'h0000, 16'hFFFF};
      vecs[7]  = '{6'd5, 16'h8000, 16'h0000, 16'h8000};
      vecs[8]  = '{6'd6, 16'h8001, 16'h0000, 16'h0002};
      vecs[9]  = '{6'd7, 16'h8002, 16'h0000, 16'hC001};
      vecs[10] = '{6'd7, 16'h4002, 16'h0000, 16'h2001};
      bad_words[0] = 16'hB000;
      bad_words[1] = 16'hF008;

      // LHI / ORI / WWD / HLT
      clear_prog("lhi_ori_wwd");
      memory[0] = enc_i(4'd6, 2'd0, 2'd1, 8'h12);
      memory[1] = enc_i(4'd5, 2'd1, 2'd1, 8'h34);
      memory[2] = enc_r(6'd28, 2'd1, 2'd0, 2'd0);
      memory[3] = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
      for (int i = 0; i < 4; i++) push_rd(16'(i));
      start();
      wait_done(cyc);
      finish_prog(16'h1234, 16'd4, 1'b1, 16, cyc);

      // Asynchronous reset while halted clears the visible state at once
      tname = "async_reset";
      #2 reset_n = 1'b0;
      #1;
      chk("rst_output_port", 32'(output_port), 32'd0);
      chk("rst_num_inst", 32'(num_inst), 32'd0);
      chk("rst_is_halted", 32'(is_halted), 32'd0);

      // Reset mid-IF drops readM immediately
      clear_prog("reset_mid_if");
      rd_budget = 0;
      start();
      @(negedge clk);
      chk("if_readM", 32'(mif.readM), 32'd1);
      chk("if_address", 32'(mif.address), 32'h0000);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_readM", 32'(mif.readM), 32'd0);
      chk("rst_writeM", 32'(mif.writeM), 32'd0);
      chk("rst_address", 32'(mif.address), 32'd0);

      // R-type ALU table
      for (int v = 0; v < 11; v++) begin
         clear_prog($sformatf("alu%0d", v));
         memory[0] = enc_i(4'd6, 2'd0, 2'd0, vecs[v].a[15:8]);
         memory[1] = enc_i(4'd5, 2'd0, 2'd0, vecs[v].a[7:0]);
         memory[2] = enc_i(4'd6, 2'd0, 2'd1, vecs[v].b[15:8]);
         memory[3] = enc_i(4'd5, 2'd1, 2'd1, vecs[v].b[7:0]);
         memory[4] = enc_r(vecs[v].fn, 2'd0, 2'd1, 2'd3);
         memory[5] = enc_r(6'd28, 2'd3, 2'd0, 2'd0);
         memory[6] = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
         for (int i = 0; i < 7; i++) push_rd(16'(i));
         start();
         wait_done(cyc);
         finish_prog(vecs[v].exp, 16'd7, 1'b1, 28, cyc);
      end

      // BLZ taken
      clear_prog("blz_taken");
      memory[0] = enc_i(4'd4, 2'd0, 2'd0, 8'hFF);
      memory[1] = enc_i(4'd3, 2'd0, 2'd0, 8'h02);
      memory[2] = enc_i(4'd4, 2'd0, 2'd0, 8'h01);
      memory[3] = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
      memory[4] = enc_r(6'd28, 2'd0, 2'd0, 2'd0);
      memory[5] = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
      push_rd(16'h0); push_rd(16'h1); push_rd(16'h4); push_rd(16'h5);
      start();
      wait_done(cyc);
      finish_prog(16'hFFFF, 16'd4, 1'b1, 16, cyc);

      // BGZ not taken on a negative value
      clear_prog("bgz_not_taken");
      memory[0] = enc_i(4'd4, 2'd0, 2'd0, 8'hFF);
      memory[1] = enc_i(4'd2, 2'd0, 2'd0, 8'h02);
      memory[2] = enc_r(6'd28, 2'd0, 2'd0, 2'd0);
      memory[3] = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
      for (int i = 0; i < 4; i++) push_rd(16'(i));
      start();
      wait_done(cyc);
      finish_prog(16'hFFFF, 16'd4, 1'b1, 16, cyc);

      // BEQ taken on equal, BNE not taken on equal
      clear_prog("beq_bne");
      memory[0] = enc_i(4'd1, 2'd1, 2'd2, 8'h01);
      memory[1] = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
      memory[2] = enc_i(4'd0, 2'd1, 2'd2, 8'h05);
      memory[3] = enc_i(4'd4, 2'd3, 2'd3, 8'h55);
      memory[4] = enc_r(6'd28, 2'd3, 2'd0, 2'd0);
      memory[5] = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
      push_rd(16'h0); push_rd(16'h2); push_rd(16'h3); push_rd(16'h4); push_rd(16'h5);
      start();
      wait_done(cyc);
      finish_prog(16'h0055, 16'd5, 1'b1, 20, cyc);

      // SWD with delayed ack, then LWD of the same word
      clear_prog("swd_lwd");
      wr_delay  = 3;
      memory[0] = enc_i(4'd4, 2'd0, 2'd0, 8'h10);
      memory[1] = enc_i(4'd5, 2'd2, 2'd2, 8'hAB);
      memory[2] = enc_i(4'd8, 2'd0, 2'd2, 8'h05);
      memory[3] = enc_i(4'd7, 2'd0, 2'd3, 8'h05);
      memory[4] = enc_r(6'd28, 2'd3, 2'd0, 2'd0);
      memory[5] = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
      push_rd(16'h0); push_rd(16'h1); push_rd(16'h2);
      push_wr(16'h0015, 16'h00AB);
      push_rd(16'h3); push_rd(16'h0015);
      push_rd(16'h4); push_rd(16'h5);
      start();
      wait_done(cyc);
      chk("wr_wait", 32'(wr_wait), 32'd3);
      chk("mem_0x15", 32'(memory[8'h15]), 32'h00AB);
      finish_prog(16'h00AB, 16'd6, 1'b1, 29, cyc);

      // JAL then JRL through the link register
      clear_prog("jal_jrl");
      memory[0]     = enc_j(4'd9, 12'h007);
      memory[7]     = enc_j(4'd10, 12'h040);
      memory[8'h40] = enc_r(6'd26, 2'd2, 2'd0, 2'd0);
      memory[8]     = enc_r(6'd28, 2'd2, 2'd0, 2'd0);
      memory[9]     = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
      push_rd(16'h0); push_rd(16'h7); push_rd(16'h40); push_rd(16'h8); push_rd(16'h9);
      start();
      wait_done(cyc);
      finish_prog(16'h0041, 16'd5, 1'b1, 20, cyc);

      // Undefined opcode and undefined func
      for (int k = 0; k < 2; k++) begin
         clear_prog($sformatf("undef%0d", k));
         memory[0] = enc_i(4'd4, 2'd0, 2'd0, 8'h01);
         memory[1] = bad_words[k];
         push_rd(16'h0); push_rd(16'h1);
         start();
         wait_done(cyc);
         finish_prog(16'h0000, 16'd1, 1'b0, 6, cyc);
      end

      // Fetch timeout after one retired instruction
      clear_prog("timeout");
      rd_budget = 1;
      memory[0] = enc_i(4'd4, 2'd0, 2'd0, 8'h01);
      memory[1] = enc_r(6'd29, 2'd0, 2'd0, 2'd0);
      push_rd(16'h0);
      start();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (num_inst == 16'd1) break;
      end
      chk("to_first_retire", 32'(num_inst), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("to_err_before", 32'(is_error), 32'd0);
      chk("to_readM_before", 32'(mif.readM), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("to_err", 32'(is_error), 32'd1);
      chk("to_readM", 32'(mif.readM), 32'd0);
      chk("to_num_inst", 32'(num_inst), 32'd1);
      chk("to_sb_missing", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      chk("to_err_hold", 32'(is_error), 32'd1);
      chk("to_readM_hold", 32'(mif.readM), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
